// File: rtl/reg_bank.sv
// Register bank feeding the ula operands, with a registered zero flag of the last accepted write.
// Optional macro REG_BYPASS_EN forwards same-edge write data to the read ports.
module reg_bank #(
  parameter  int BITS = 8,
  parameter  int REGS = 4,
  localparam int ADDR = $clog2(REGS)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            we_in,
  input  logic [ADDR-1:0] waddr_in,
  input  logic [BITS-1:0] wdata_in,
  input  logic            re_in,
  input  logic [ADDR-1:0] ra_addr_in,
  input  logic [ADDR-1:0] rb_addr_in,
  output logic [BITS-1:0] a_out,
  output logic [BITS-1:0] b_out,
  output logic            zero_out
);

  localparam logic [ADDR:0] REGS_W = REGS[ADDR:0];

  logic [BITS-1:0] regs [REGS];
  logic            wr_valid;
  logic [BITS-1:0] rd_a;
  logic [BITS-1:0] rd_b;

  // Writes to addresses beyond the array (non power-of-two REGS) are ignored entirely.
  assign wr_valid = we_in && ({1'b0, waddr_in} < REGS_W);

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < REGS; i++) begin
      if ({1'b0, ra_addr_in} == i[ADDR:0]) rd_a = regs[i];
      if ({1'b0, rb_addr_in} == i[ADDR:0]) rd_b = regs[i];
    end
`ifdef REG_BYPASS_EN
    if (wr_valid && (ra_addr_in == waddr_in)) rd_a = wdata_in;
    if (wr_valid && (rb_addr_in == waddr_in)) rd_b = wdata_in;
`else
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
      zero_out <= 1'b1;
    end else if (wr_valid) begin
      for (int i = 0; i < REGS; i++) begin
        if ({1'b0, waddr_in} == i[ADDR:0]) regs[i] <= wdata_in;
      end
      zero_out <= (wdata_in == '0);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_out <= '0;
      b_out <= '0;
    end else if (re_in) begin
      a_out <= rd_a;
      b_out <= rd_b;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank; expectations follow the REG_BYPASS_EN setting of the build.
module tb_reg_bank;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       we_in = 1'b0;
   logic [1:0] waddr_in = '0;
   logic [7:0] wdata_in = '0;
   logic       re_in = 1'b0;
   logic [1:0] ra_addr_in = '0;
   logic [1:0] rb_addr_in = '0;
   logic [7:0] a_out;
   logic [7:0] b_out;
   logic       zero_out;

   int totalChecks = 0;
   int badChecks = 0;

   reg_bank #(.BITS(8), .REGS(4)) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .we_in(we_in),
      .waddr_in(waddr_in),
      .wdata_in(wdata_in),
      .re_in(re_in),
      .ra_addr_in(ra_addr_in),
      .rb_addr_in(rb_addr_in),
      .a_out(a_out),
      .b_out(b_out),
      .zero_out(zero_out)
   );

   always #5 clk_in = ~clk_in;

   // Drive one cycle of inputs, let the rising edge take them, then settle 1 ns.
   task automatic applyStimulus(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                                input logic re, input logic [1:0] ra, input logic [1:0] rb);
      we_in = we; waddr_in = wa; wdata_in = wd;
      re_in = re; ra_addr_in = ra; rb_addr_in = rb;
      @(posedge clk_in);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, observed, expected);
      end
   endtask

   logic [7:0] sameEdgeExp;
   logic [7:0] shiftExp;

   initial begin
`ifdef REG_BYPASS_EN
      sameEdgeExp = 8'h22;
`else
      sameEdgeExp = 8'h11;
`endif
      shiftExp = 8'h01 << 3;

      #12;
      checkOutput("reset_a", a_out, 8'h00);
      checkOutput("reset_b", b_out, 8'h00);
      checkOutput("reset_zero", {7'b0, zero_out}, 8'h01);
      @(negedge clk_in);
      rst_in = 1'b0;

      applyStimulus(1, 2'd1, 8'h3C, 0, 2'd0, 2'd0);
      checkOutput("zero_after_3c", {7'b0, zero_out}, 8'h00);
      applyStimulus(1, 2'd3, 8'hC3, 0, 2'd0, 2'd0);
      applyStimulus(0, 2'd0, 8'h00, 1, 2'd1, 2'd3);
      checkOutput("read_a_r1", a_out, 8'h3C);
      checkOutput("read_b_r3", b_out, 8'hC3);

      applyStimulus(0, 2'd0, 8'h00, 0, 2'd3, 2'd1);
      checkOutput("hold_a", a_out, 8'h3C);
      checkOutput("hold_b", b_out, 8'hC3);

      applyStimulus(0, 2'd0, 8'h00, 1, 2'd3, 2'd3);
      checkOutput("same_addr_a", a_out, 8'hC3);
      checkOutput("same_addr_b", b_out, 8'hC3);

      applyStimulus(1, 2'd0, 8'h11, 0, 2'd0, 2'd0);
      applyStimulus(1, 2'd0, 8'h22, 1, 2'd0, 2'd1);
      checkOutput("same_edge_a", a_out, sameEdgeExp);
      checkOutput("same_edge_other_b", b_out, 8'h3C);
      applyStimulus(0, 2'd0, 8'h00, 1, 2'd0, 2'd0);
      checkOutput("after_write_a", a_out, 8'h22);

      applyStimulus(1, 2'd2, 8'h00, 0, 2'd0, 2'd0);
      checkOutput("zero_on_00", {7'b0, zero_out}, 8'h01);
      applyStimulus(1, 2'd2, 8'h80, 0, 2'd0, 2'd0);
      checkOutput("zero_on_80", {7'b0, zero_out}, 8'h00);
      applyStimulus(0, 2'd2, 8'h00, 0, 2'd0, 2'd0);
      checkOutput("zero_hold", {7'b0, zero_out}, 8'h00);

      // ula loop: r0 << r1 written back into r2.
      applyStimulus(1, 2'd0, 8'h01, 0, 2'd0, 2'd0);
      applyStimulus(1, 2'd1, 8'h03, 0, 2'd0, 2'd0);
      applyStimulus(0, 2'd0, 8'h00, 1, 2'd0, 2'd1);
      checkOutput("loop_a", a_out, 8'h01);
      checkOutput("loop_b", b_out, 8'h03);
      applyStimulus(1, 2'd2, shiftExp, 0, 2'd0, 2'd0);
      applyStimulus(0, 2'd0, 8'h00, 1, 2'd2, 2'd2);
      checkOutput("loop_r2", a_out, 8'h08);

      // Asynchronous reset in the middle of a cycle, with a write pending on a reset-high edge.
      applyStimulus(1, 2'd2, 8'hA5, 0, 2'd0, 2'd0);
      applyStimulus(0, 2'd0, 8'h00, 1, 2'd2, 2'd2);
      checkOutput("pre_reset_a", a_out, 8'hA5);
      #2;
      rst_in = 1'b1;
      #1;
      checkOutput("async_reset_a", a_out, 8'h00);
      checkOutput("async_reset_b", b_out, 8'h00);
      checkOutput("async_reset_zero", {7'b0, zero_out}, 8'h01);
      applyStimulus(1, 2'd3, 8'h55, 1, 2'd1, 2'd1);
      checkOutput("reset_edge_read", a_out, 8'h00);
      @(negedge clk_in);
      rst_in = 1'b0;
      applyStimulus(0, 2'd0, 8'h00, 1, 2'd2, 2'd3);
      checkOutput("post_reset_r2", a_out, 8'h00);
      checkOutput("post_reset_r3", b_out, 8'h00);
      checkOutput("post_reset_zero", {7'b0, zero_out}, 8'h01);
      applyStimulus(1, 2'd1, 8'h7E, 0, 2'd0, 2'd0);
      applyStimulus(0, 2'd0, 8'h00, 1, 2'd1, 2'd0);
      checkOutput("post_reset_write_r1", a_out, 8'h7E);
      checkOutput("post_reset_r0", b_out, 8'h00);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/reg_bank.md
# reg_bank

General-purpose register bank that sits directly upstream of the `ula`: its two registered read ports drive `ula` `a_in`/`b_in`, and its write port takes the `ula` `result_out` back in. Holds `REGS` words of `BITS` bits, one synchronous write port and two synchronous read ports with one-cycle read latency. It also keeps a registered zero flag of the last written value for the branch logic.

## Interface
- `BITS`, 8, data word width; must match the `ula` `BITS`.
- `REGS`, 4, number of registers; any value ≥ 2.
- `ADDR`, `$clog2(REGS)`, address width; derived, not overridden.

- `clk_in`  input  1  clock; all state changes on the rising edge.
- `rst_in`  input  1  reset, asynchronous, active-high.
- `we_in`  input  1  write enable.
- `waddr_in`  input  `ADDR`  write address.
- `wdata_in`  input  `BITS`  write data (normally the `ula` `result_out`).
- `re_in`  input  1  read enable; low holds `a_out`/`b_out`.
- `ra_addr_in`  input  `ADDR`  read address, port A.
- `rb_addr_in`  input  `ADDR`  read address, port B.
- `a_out`  output  `BITS`  registered read data A, to the `ula` `a_in`.
- `b_out`  output  `BITS`  registered read data B, to the `ula` `b_in`.
- `zero_out`  output  1  registered flag, 1 when the last accepted write data was 0.

## Operation
- Storage: `REGS` × `BITS` flops. There is no hardwired-zero register, so every register is writable.
- Write: on a rising edge with `we_in`=1 and `waddr_in` < `REGS`, `regs[waddr_in]` ← `wdata_in`. On that same edge, `zero_out` ← (`wdata_in` == 0).
- Write to an address ≥ `REGS` (possible only when `REGS` is not a power of two): the register array is unchanged and `zero_out` is unchanged.
- Read: on a rising edge with `re_in`=1, `a_out` ← word at `ra_addr_in` and `b_out` ← word at `rb_addr_in`. With `re_in`=0 both outputs hold their values.
- Read of an address ≥ `REGS` returns 0.
- Both ports may read the same address, and each gets the same value.
- Read and write to the same address on the same edge: the result is governed by `REG_BYPASS_EN` (see Configuration).
- Read and write to different addresses on the same edge are independent of each other.
- Data passes through unmodified. There is no arithmetic or width conversion.

## Timing
- Read latency is 1 cycle: an address presented before edge N is visible on `a_out`/`b_out` after edge N.
- Write latency is 1 cycle: data written at edge N is readable from storage at edge N+1 and later.
- `zero_out` updates at the same edge as the write it reflects.
- Reset values: every register = 0, `a_out` = 0, `b_out` = 0, `zero_out` = 1.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. A write or read pending on the edge at which `rst_in` is high is discarded.
- Reset release: the first edge after `rst_in` falls behaves normally.
- There is no handshake or stall. The bank accepts one write and one read pair every cycle.

## Configuration
- Macro: `REG_BYPASS_EN`.
- Defined: a read at edge N whose address equals `waddr_in` with a valid write at the same edge returns `wdata_in`. This is write-to-read forwarding and applies to each port independently.
- Undefined: that same read returns the value stored before edge N. The new value is visible from edge N+1.
- `zero_out` and all other behaviour are identical in both builds.

## Test plan
- Reset: drive `rst_in`=1 asynchronously mid-cycle after writing 0xA5 to r2 → `a_out`=`b_out`=0x00 and `zero_out`=1 immediately; reading r2 after release returns 0x00.
- Write/read: write 0x3C to r1 and 0xC3 to r3, then read A=r1, B=r3 → one cycle later `a_out`=0x3C, `b_out`=0xC3.
- Hold: with A=0x3C on the output, set `re_in`=0 and change `ra_addr_in` to r3 → `a_out` stays 0x3C.
- Same-edge read/write: r0 holds 0x11; write 0x22 to r0 while reading A=r0 → `a_out`=0x22 with `REG_BYPASS_EN` defined, 0x11 without it; both builds read 0x22 on the next read.
- Zero flag: write 0x00 → `zero_out`=1; write 0x80 → `zero_out`=0; cycle with `we_in`=0 → `zero_out` stays 0.
- Loop with `ula`: r0=0x01, r1=0x03, `ula_op_in`=6 (left shift), `result_out` wired to `wdata_in` with `waddr_in`=r2 → r2 reads 0x08 on the next read.
